hazard_control_unit: RTL

// - Pipeline stall/flush controller; the counterpart to forwarding in the 5-stage MIPS core.
// - Forwarding resolves hazards it can bypass. This block handles the rest:

---
 rtl/hazard_control_unit.sv | 125 ++++++++++++
 1 files changed

// File: rtl/hazard_control_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use, redirect, I/D-cache waits and halt.
// Optional stall-cycle counter enabled by defining HAZARD_PERF_EN.
module hazard_control_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic [4:0] Rs_id,
  input  logic [4:0] Rt_id,
  input  logic       MemRd_ex,
  input  logic [4:0] RegDst_ex,
  input  logic       dREN_mem,
  input  logic       dWEN_mem,
  input  logic       dhit,
  input  logic       ihit,
  input  logic       redirect_mem,
  input  logic       halt_wb,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       ifid_flush,
  output logic       idex_en,
  output logic       idex_flush,
  output logic       exmem_en,
  output logic       exmem_flush,
  output logic       memwb_en,
  output logic       halted
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDwait = 2'd1,
    StHalt  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic dmem_busy;
  logic load_use;
  logic halt_req;

  assign dmem_busy = (dREN_mem | dWEN_mem) & ~dhit;
  assign load_use  = MemRd_ex && (RegDst_ex != 5'd0) &&
                     ((RegDst_ex == Rs_id) || (RegDst_ex == Rt_id));
  // halt_wb is only honoured from RUN; a DWAIT exit cycle evaluates rules 3-5 only.
  assign halt_req  = (state_q == StHalt) || ((state_q == StRun) && halt_wb);

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_en    = 1'b1;
    exmem_flush = 1'b0;
    memwb_en    = 1'b1;
    state_d     = StRun;

    if (halt_req) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      state_d  = StHalt;
    end else if (dmem_busy) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      state_d  = StDwait;
    end else if (redirect_mem) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (load_use) begin
      // Hold IF/ID and insert one bubble into EX; the bubble clears the match next cycle.
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (!ihit) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end

    if (!nRST) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b0;
      idex_en     = 1'b0;
      idex_flush  = 1'b0;
      exmem_en    = 1'b0;
      exmem_flush = 1'b0;
      memwb_en    = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StRun;
      halted  <= 1'b0;
    end else begin
      state_q <= state_d;
      halted  <= (state_d == StHalt);
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
    end else if (!pc_en && (state_q != StHalt) && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule
